// File: rtl/reset_release_sequencer.sv
// Reset release sequencer: synchronizes rst_n deassertion, qualifies it with
// PLL lock, then releases the per-domain resets one by one in index order.
module reset_release_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_DOMAINS = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pll_locked,
    input  logic                   soft_rst_req,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   seq_done,
    output logic                   busy
);

    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        HOLD,
        RELEASE,
        RUN
    } state_e;

    logic [SYNC_STAGES-1:0] rel_sync_q;
    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic                   rel_q;
    logic                   lock_s;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;

    assign rel_q  = rel_sync_q[SYNC_STAGES-1];
    assign lock_s = lock_sync_q[SYNC_STAGES-1];

    // Deassert and lock synchronizers, both cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rel_sync_q  <= '0;
            lock_sync_q <= '0;
        end else begin
            rel_sync_q  <= {rel_sync_q[SYNC_STAGES-2:0], 1'b1};
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    // Sequencer state and registered outputs; reset only drives domains to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: lock loss beats soft request, which beats sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dom_d   = dom_q;
        done_d  = done_q;
        if (state_q == WAIT_LOCK) begin
            dom_d  = '1;
            done_d = 1'b0;
            if (rel_q && lock_s) begin
                state_d = HOLD;
                cnt_d   = CW'(HOLD_CYCLES);
            end
        end else if (!lock_s) begin
            state_d = WAIT_LOCK;
            dom_d   = '1;
            done_d  = 1'b0;
        end else if (soft_rst_req) begin
            state_d = HOLD;
            cnt_d   = CW'(HOLD_CYCLES);
            dom_d   = '1;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_q == CW'(1)) begin
                        dom_d[0] = 1'b0;
                        if (NUM_DOMAINS == 1) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RELEASE;
                            cnt_d   = CW'(GAP_CYCLES);
                            idx_d   = IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                RELEASE: begin
                    if (cnt_q == CW'(1)) begin
                        for (int i = 0; i < NUM_DOMAINS; i++) begin
                            if (IW'(i) == idx_q) dom_d[i] = 1'b0;
                        end
                        if (idx_q == IW'(NUM_DOMAINS - 1)) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                            cnt_d = CW'(GAP_CYCLES);
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    dom_d  = '0;
                    done_d = 1'b1;
                end
            endcase
        end
        busy_d = (state_d == HOLD) || (state_d == RELEASE);
    end

    assign domain_rst = dom_q;
    assign seq_done   = done_q;
    assign busy       = busy_q;

endmodule
